// File: rtl/link_credit_rx_if.sv
// ============================================================================
// link_credit_rx_if : link-side and consumer-side signals of link_credit_rx
// Rev 1.0
// ============================================================================
`default_nettype none

interface link_credit_rx_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              credit_out;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  occupancy;
    logic              ovf;

    // slave = the receiver block; master = sender plus consumer around it
    modport slave (
        input  in_valid, in_data, out_ready,
        output credit_out, out_valid, out_data, occupancy, ovf
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  credit_out, out_valid, out_data, occupancy, ovf
    );
endinterface

`default_nettype wire

// File: rtl/link_credit_rx.sv
// ============================================================================
// link_credit_rx : credit-flow-controlled link receiver with DEPTH-entry FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module link_credit_rx #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    link_credit_rx_if.slave lnk
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]  occupancy_q, occupancy_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              credit_q, credit_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              ovf_q, ovf_d;
    logic              pop;
    logic              push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        pop         = out_valid_q & lnk.out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts
        push        = lnk.in_valid & ((occupancy_q < CNT_W'(DEPTH)) | pop);

        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        credit_d    = pop;

        case (state_q)
            ST_INIT: begin
                credit_d   = 1'b1;
                init_cnt_d = init_cnt_q - CNT_W'(1);
                if (init_cnt_q == CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                credit_d = pop;
            end
        endcase

        wptr_d      = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d      = pop  ? ptr_inc(rptr_q) : rptr_q;

        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q] = lnk.in_data;
        end

        occupancy_d = occupancy_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d       = ovf_q | (lnk.in_valid & ~push);

        // Head is read from the post-write image so a word written this cycle
        // into an empty (or just-drained) FIFO is presented straight away
        out_valid_d = (occupancy_d != '0);
        out_data_d  = out_valid_d ? mem_d[rptr_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= CNT_W'(DEPTH);
            occupancy_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_q       <= '{default: '0};
            credit_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            occupancy_q <= occupancy_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_q       <= mem_d;
            credit_q    <= credit_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign lnk.credit_out = credit_q;
    assign lnk.out_valid  = out_valid_q;
    assign lnk.out_data   = out_data_q;
    assign lnk.occupancy  = occupancy_q;
    assign lnk.ovf        = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_link_credit_rx.sv
// ============================================================================
// tb_link_credit_rx : directed self-checking bench for link_credit_rx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_link_credit_rx;

    logic clk = 1'b0;
    logic rst4_n;
    logic rst3_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   credits3 = 0;

    always #5 clk = ~clk;

    link_credit_rx_if #(.DATA_W(32), .CNT_W(5)) if4 ();
    link_credit_rx_if #(.DATA_W(32), .CNT_W(5)) if3 ();

    link_credit_rx #(.DATA_W(32), .DEPTH(4), .CNT_W(5)) u_dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .lnk   (if4.slave)
    );

    link_credit_rx #(.DATA_W(32), .DEPTH(3), .CNT_W(5)) u_dut3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .lnk   (if3.slave)
    );

    always @(posedge clk) begin
        if (if3.credit_out === 1'b1) credits3 <= credits3 + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp4 [4];
        int          rx;
        int          pulses;
        logic        any_valid;

        rst4_n = 1'b0;
        rst3_n = 1'b0;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b0;
        if3.in_valid = 1'b0; if3.in_data = '0; if3.out_ready = 1'b0;
        step();
        step();

        // Reset state
        check_val("rst_credit",  if4.credit_out, 0);
        check_val("rst_valid",   if4.out_valid,  0);
        check_val("rst_data",    if4.out_data,   0);
        check_val("rst_occ",     if4.occupancy,  0);
        check_val("rst_ovf",     if4.ovf,        0);
        check_val("rst3_credit", if3.credit_out, 0);

        // Init credits: DEPTH pulses on cycles 1..DEPTH after release
        rst4_n = 1'b1;
        rst3_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check_val($sformatf("init4_credit_c%0d", i), if4.credit_out, (i <= 4) ? 1 : 0);
            check_val($sformatf("init3_credit_c%0d", i), if3.credit_out, (i <= 3) ? 1 : 0);
        end
        check_val("init_occ", if4.occupancy, 0);
        check_val("init_ovf", if4.ovf,       0);

        // Single word, held head, pop and returned credit
        if4.in_valid = 1'b1; if4.in_data = 32'hA5A5_0001;
        step();
        if4.in_valid = 1'b0;
        check_val("t2_valid", if4.out_valid, 1);
        check_val("t2_data",  if4.out_data,  32'hA5A5_0001);
        check_val("t2_occ",   if4.occupancy, 1);
        step();
        check_val("t2_hold_data",   if4.out_data,   32'hA5A5_0001);
        check_val("t2_hold_credit", if4.credit_out, 0);
        if4.out_ready = 1'b1;
        step();
        if4.out_ready = 1'b0;
        check_val("t2_pop_valid",  if4.out_valid,  0);
        check_val("t2_pop_credit", if4.credit_out, 1);
        step();
        check_val("t2_credit_end", if4.credit_out, 0);
        check_val("t2_occ_end",    if4.occupancy,  0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            if4.in_valid = 1'b1; if4.in_data = 32'h10 + i;
            step();
        end
        check_val("t4_full_occ",  if4.occupancy, 4);
        check_val("t4_full_head", if4.out_data,  32'h10);
        if4.in_data = 32'h55; if4.out_ready = 1'b1;
        step();
        if4.in_valid = 1'b0;
        check_val("t4_ovf",    if4.ovf,        0);
        check_val("t4_occ",    if4.occupancy,  4);
        check_val("t4_credit", if4.credit_out, 1);
        exp4 = '{32'h11, 32'h12, 32'h13, 32'h55};
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t4_drain_valid%0d", i), if4.out_valid, 1);
            check_val($sformatf("t4_drain_data%0d", i),  if4.out_data,  exp4[i]);
            step();
            check_val($sformatf("t4_drain_credit%0d", i), if4.credit_out, 1);
        end
        if4.out_ready = 1'b0;
        check_val("t4_empty", if4.out_valid, 0);
        step();
        check_val("t4_credit_end", if4.credit_out, 0);

        // Overflow: fifth word dropped, ovf sticky
        for (int i = 1; i <= 5; i++) begin
            if4.in_valid = 1'b1; if4.in_data = i;
            step();
        end
        if4.in_valid = 1'b0;
        check_val("t3_ovf",    if4.ovf,       1);
        check_val("t3_occ",    if4.occupancy, 4);
        check_val("t3_credit", if4.credit_out, 0);
        step();
        check_val("t3_ovf_sticky", if4.ovf, 1);
        if4.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_val($sformatf("t3_drain_valid%0d", i), if4.out_valid, 1);
            check_val($sformatf("t3_drain_data%0d", i),  if4.out_data,  i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("t3_no_extra%0d", i), if4.out_valid, 0);
            step();
        end
        if4.out_ready = 1'b0;
        check_val("t3_occ_end", if4.occupancy, 0);
        check_val("t3_ovf_end", if4.ovf,       1);

        // Streaming on DEPTH=3 across pointer wrap
        rx = 0;
        if3.out_ready = 1'b1;
        for (int k = 0; k < 26; k++) begin
            if (if3.out_valid === 1'b1) begin
                check_val($sformatf("t5_data%0d", rx), if3.out_data, 32'h100 + rx);
                rx++;
            end
            if (k < 20) begin
                if3.in_valid = 1'b1; if3.in_data = 32'h100 + k;
            end else begin
                if3.in_valid = 1'b0;
            end
            step();
        end
        step();
        check_val("t5_count",   rx,       20);
        check_val("t5_ovf",     if3.ovf,  0);
        check_val("t5_credits", credits3, 23);

        // Mid-operation reset discards contents and reissues init credits
        if4.in_valid = 1'b1; if4.in_data = 32'h7;
        step();
        if4.in_data = 32'h8;
        step();
        if4.in_valid = 1'b0;
        check_val("t6_pre_occ", if4.occupancy, 2);
        check_val("t6_pre_ovf", if4.ovf,       1);
        rst4_n = 1'b0;
        step();
        check_val("t6_rst_credit", if4.credit_out, 0);
        check_val("t6_rst_valid",  if4.out_valid,  0);
        check_val("t6_rst_data",   if4.out_data,   0);
        check_val("t6_rst_occ",    if4.occupancy,  0);
        check_val("t6_rst_ovf",    if4.ovf,        0);
        rst4_n = 1'b1;
        pulses = 0;
        any_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (if4.credit_out === 1'b1) pulses++;
            if (if4.out_valid !== 1'b0) any_valid = 1'b1;
        end
        check_val("t6_init_credits", pulses,    4);
        check_val("t6_no_data",      any_valid, 0);
        check_val("t6_occ",          if4.occupancy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
